// File: rtl/is_pkg_uart_controller.sv
// rtl/is_pkg_uart_controller.sv - shared types and constants for the UART command controller
package is_pkg_uart_controller;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND_MSG,
    HEX,
    CR,
    LF,
    DONE
  } tx_seq_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam int ERR_A0_DEF = 0;
  localparam int ERR_A1_DEF = 2;
  localparam int PRE_A0_DEF = 4;
  localparam int PRE_A1_DEF = 5;

endpackage

// File: rtl/is_nib2ascii.sv
// rtl/is_nib2ascii.sv - 4-bit nibble to uppercase ASCII hex character
module is_nib2ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    ascii = 8'h00;
    if (nibble < 4'd10) ascii = 8'h30 + {4'h0, nibble};
    else                ascii = 8'h37 + {4'h0, nibble};
  end

endmodule

// File: rtl/is_tx_seq.sv
// rtl/is_tx_seq.sv - response line sequencer: ROM string, optional hex result, CR LF
module is_tx_seq
  import is_pkg_uart_controller::*;
#(
  parameter int DATA_W    = 8,
  parameter int RES_W     = 16,
  parameter int MEM_WIDTH = 5,
  parameter int ERR_A0    = ERR_A0_DEF,
  parameter int ERR_A1    = ERR_A1_DEF,
  parameter int PRE_A0    = PRE_A0_DEF,
  parameter int PRE_A1    = PRE_A1_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 err_i,
  input  logic [RES_W-1:0]     res_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [MEM_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_W-1:0]    rom_data_i,
  input  logic                 tx_rdy_i,
  output logic                 tx_vld_o,
  output logic [DATA_W-1:0]    tx_data_o
);

  localparam int NDIG  = RES_W / 4;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  // Addresses are truncated to the ROM width so the end compare never wraps.
  localparam logic [MEM_WIDTH-1:0] ERR_START = MEM_WIDTH'(ERR_A0);
  localparam logic [MEM_WIDTH-1:0] ERR_END   = MEM_WIDTH'(ERR_A1);
  localparam logic [MEM_WIDTH-1:0] PRE_START = MEM_WIDTH'(PRE_A0);
  localparam logic [MEM_WIDTH-1:0] PRE_END   = MEM_WIDTH'(PRE_A1);
  localparam logic [CNT_W-1:0]     LAST_DIG  = CNT_W'(NDIG - 1);

  tx_seq_state_t        state;
  logic [RES_W-1:0]     res_q;
  logic                 err_q;
  logic [CNT_W-1:0]     dig_cnt;
  logic [RES_W-1:0]     res_shift;
  logic [7:0]           hex_char;
  logic [MEM_WIDTH-1:0] end_addr;
  logic                 xfer;

  assign xfer      = tx_vld_o && tx_rdy_i;
  assign end_addr  = err_q ? ERR_END : PRE_END;
  assign res_shift = res_q << {dig_cnt, 2'b00};

  is_nib2ascii u_nib2ascii (
    .nibble (res_shift[RES_W-1 -: 4]),
    .ascii  (hex_char)
  );

  // Each byte-producing state loads tx_data_o when tx_vld_o is low and
  // advances on the transfer cycle, which also drops tx_vld_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      res_q      <= '0;
      err_q      <= 1'b0;
      dig_cnt    <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      rom_addr_o <= '0;
      tx_vld_o   <= 1'b0;
      tx_data_o  <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            res_q      <= res_i;
            err_q      <= err_i;
            rom_addr_o <= err_i ? ERR_START : PRE_START;
            busy_o     <= 1'b1;
            state      <= FETCH;
          end
        end
        FETCH: state <= SEND_MSG;
        SEND_MSG: begin
          if (!tx_vld_o) begin
            tx_data_o <= rom_data_i;
            tx_vld_o  <= 1'b1;
          end else if (tx_rdy_i) begin
            tx_vld_o <= 1'b0;
            if (rom_addr_o == end_addr) begin
              state <= err_q ? CR : HEX;
            end else begin
              rom_addr_o <= rom_addr_o + 1'b1;
              state      <= FETCH;
            end
          end
        end
        HEX: begin
          if (!tx_vld_o) begin
            tx_data_o <= DATA_W'(hex_char);
            tx_vld_o  <= 1'b1;
          end else if (tx_rdy_i) begin
            tx_vld_o <= 1'b0;
            if (dig_cnt == LAST_DIG) begin
              dig_cnt <= '0;
              state   <= CR;
            end else begin
              dig_cnt <= dig_cnt + 1'b1;
            end
          end
        end
        CR: begin
          if (!tx_vld_o) begin
            tx_data_o <= DATA_W'(ASCII_CR);
            tx_vld_o  <= 1'b1;
          end else if (xfer) begin
            tx_vld_o <= 1'b0;
            state    <= LF;
          end
        end
        LF: begin
          if (!tx_vld_o) begin
            tx_data_o <= DATA_W'(ASCII_LF);
            tx_vld_o  <= 1'b1;
          end else if (xfer) begin
            tx_vld_o <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b1;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_is_tx_seq.sv
// tb/tb_is_tx_seq.sv - scoreboard bench for is_tx_seq
module tb_is_tx_seq;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        err_i = 1'b0;
  logic [15:0] res_i = '0;
  logic        busy_o, done_o;
  logic [4:0]  rom_addr_o;
  logic [7:0]  rom_data_i;
  logic        tx_rdy_i = 1'b1;
  logic        tx_vld_o;
  logic [7:0]  tx_data_o;

  logic [7:0]  rom [32];
  logic [7:0]  exp_q [$];
  int          tests = 0;
  int          fails = 0;
  int          xfers = 0;
  int          done_seen = 0;
  bit          bp_mode = 1'b0;
  bit          stall_q = 1'b0;
  logic [7:0]  stall_data = '0;

  always #5 clk = ~clk;

  is_tx_seq dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .err_i      (err_i),
    .res_i      (res_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .rom_addr_o (rom_addr_o),
    .rom_data_i (rom_data_i),
    .tx_rdy_i   (tx_rdy_i),
    .tx_vld_o   (tx_vld_o),
    .tx_data_o  (tx_data_o)
  );

  always @(posedge clk) rom_data_i <= rom[rom_addr_o];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_rdy_i = bp_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst_i) begin
      if (stall_q && tx_vld_o) check("hold_stable", tx_data_o, stall_data);
      if (tx_vld_o && tx_rdy_i) begin
        xfers++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_byte: got %0h expected none", tx_data_o);
        end else begin
          check("byte", tx_data_o, exp_q.pop_front());
        end
      end
      if (done_o) done_seen++;
    end
    stall_q    = tx_vld_o && !tx_rdy_i && !rst_i;
    stall_data = tx_data_o;
  end

  task automatic push_bytes(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v[8*(n-1-i) +: 8]);
  endtask

  task automatic pulse_start(input logic e, input logic [15:0] r);
    @(posedge clk);
    #1;
    start_i = 1'b1;
    err_i   = e;
    res_i   = r;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_o && n < 2000);
    if (!done_o) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no done_o expected done_o within 2000 cycles", name);
    end
  endtask

  task automatic finish_line(input string name, input int done_before);
    wait_done(name);
    check({name, "_busy_in_done"}, busy_o, 1'b0);
    @(negedge clk);
    check({name, "_done_one_cycle"}, done_o, 1'b0);
    check({name, "_busy_after"}, busy_o, 1'b0);
    check({name, "_done_count"}, done_seen - done_before, 1);
    check({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int d0;
    int x0;
    int n;
    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    rom[0] = 8'h45; rom[1] = 8'h52; rom[2] = 8'h52;
    rom[4] = 8'h52; rom[5] = 8'h3D;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_vld", tx_vld_o, 1'b0);
    check("rst_data", tx_data_o, 8'h00);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_addr", rom_addr_o, 5'd0);
    rst_i = 1'b0;

    // 1: success line
    d0 = done_seen;
    push_bytes(64'h52_3D_31_41_32_46_0D_0A, 8);
    pulse_start(1'b0, 16'h1A2F);
    @(negedge clk);
    check("s1_busy", busy_o, 1'b1);
    finish_line("s1", d0);

    // 2: error line, no hex digits
    d0 = done_seen;
    push_bytes(64'h45_52_52_0D_0A, 5);
    pulse_start(1'b1, 16'hFFFF);
    finish_line("s2", d0);

    // 3: result boundaries
    d0 = done_seen;
    push_bytes(64'h52_3D_30_30_30_30_0D_0A, 8);
    pulse_start(1'b0, 16'h0000);
    finish_line("s3_zero", d0);
    d0 = done_seen;
    push_bytes(64'h52_3D_46_46_46_46_0D_0A, 8);
    pulse_start(1'b0, 16'hFFFF);
    finish_line("s3_ffff", d0);

    // 4: backpressure
    bp_mode = 1'b1;
    d0 = done_seen;
    push_bytes(64'h52_3D_31_41_32_46_0D_0A, 8);
    pulse_start(1'b0, 16'h1A2F);
    finish_line("s4", d0);
    bp_mode = 1'b0;

    // 5: starts during busy and in DONE are ignored, next IDLE start accepted
    d0 = done_seen;
    push_bytes(64'h52_3D_31_41_32_46_0D_0A, 8);
    pulse_start(1'b0, 16'h1A2F);
    repeat (4) pulse_start(1'b1, 16'hFFFF);
    wait_done("s5a");
    start_i = 1'b1;
    err_i   = 1'b1;
    res_i   = 16'hFFFF;
    @(posedge clk);
    #1;
    push_bytes(64'h52_3D_30_30_30_30_0D_0A, 8);
    err_i = 1'b0;
    res_i = 16'h0000;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    finish_line("s5", d0 + 1);

    // 6: reset after the third byte abandons the line
    d0 = done_seen;
    x0 = xfers;
    push_bytes(64'h52_3D_31_41_32_46_0D_0A, 8);
    pulse_start(1'b0, 16'h1A2F);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (xfers < x0 + 3 && n < 200);
    check("s6_three_bytes", xfers - x0, 3);
    rst_i = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("s6_rst_vld", tx_vld_o, 1'b0);
    check("s6_rst_busy", busy_o, 1'b0);
    check("s6_rst_done", done_o, 1'b0);
    check("s6_rst_addr", rom_addr_o, 5'd0);
    check("s6_rst_data", tx_data_o, 8'h00);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    repeat (20) @(negedge clk);
    check("s6_no_done", done_seen - d0, 0);
    push_bytes(64'h52_3D_31_41_32_46_0D_0A, 8);
    pulse_start(1'b0, 16'h1A2F);
    finish_line("s6", d0);

    repeat (10) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
